hack_data_memory: RTL and testbench
===================================

// Module: hack_data_memory
// PURPOSE
//  Data-memory stage directly downstream of the CPU. It consumes outM/writeM/addressM and returns inM.
//  It decodes the Hack memory map: RAM, screen, keyboard.
//  Screen writes are kept in a shadow RAM for readback and are forwarded to the display controller
//  through a small valid/ready write queue.
//  The CPU has no stall input, so queue overflow drops the write and records it.
// PARAMETERS
//  SCR_FIFO_DEPTH  8  screen write-queue entries; power of 2, >= 2
//  DROP_CNT_W      8  width of the saturating dropped-write counter
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous, active-high reset
//  addressM    in   16  CPU data address; bit 15 ignored, only [14:0] decoded
//  outM        in   16  CPU write data
//  writeM      in   1   CPU write strobe, sampled on rising edge of clk
//  inM         out  16  read data to CPU, combinational from addressM
//  kbd_valid   in   1   keyboard interface has a new code this cycle (same clock domain)
//  kbd_code    in   16  key code; 0 = no key pressed
//  scr_valid   out  1   queue head holds a screen write
//  scr_ready   in   1   display controller accepts the head entry
//  scr_addr    out  13  screen word offset of head entry (addressM - 0x4000)
//  scr_data    out  16  screen pixel word of head entry
//  scr_ovf     out  1   sticky: at least one screen write dropped since reset
//  scr_drops   out  DROP_CNT_W  count of dropped screen writes, saturating
// BEHAVIOUR
//  Address map, on a = addressM[14:0]:
//   - 0x0000-0x3FFF  RAM, 16K x 16
//   - 0x4000-0x5FFF  screen shadow, 8K x 16
//   - 0x6000         keyboard register, read-only
//   - 0x6001-0x7FFF  unmapped: reads 0, writes ignored
//  Reads:
//   - inM is asynchronous/combinational from the arrays, zero latency.
//   - A read in the same cycle as a write to that address returns the OLD value.
//   - The new value is visible from the next cycle.
//  Writes:
//   - When writeM=1, RAM or screen shadow updates at the rising edge.
//   - Writes to 0x6000 and to unmapped addresses have no effect.
//  Keyboard:
//   - kbd_valid=1 loads kbd_code into the keyboard register at the edge; it holds otherwise.
//   - Both kbd_valid and an inM read of 0x6000 in one cycle returns the old value.
//  Screen queue:
//   - Push: writeM=1 with 0x4000<=a<=0x5FFF. The entry is {a-0x4000, outM}.
//   - The shadow RAM is always written, even if the push is dropped.
//   - Pop: scr_valid && scr_ready. scr_valid = !empty.
//   - scr_addr/scr_data come from the head entry and must stay stable while scr_valid && !scr_ready.
//   - Queue is strict FIFO order. Read/write pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//   - Full and no pop: the push is dropped, scr_ovf<=1, and scr_drops increments (holds at all-ones).
//   - Full with a simultaneous pop: the push is accepted. Occupancy is unchanged.
//   - Empty with a simultaneous push: no pop. scr_valid rises the next cycle; there is no bypass.
//   - Occupancy never exceeds SCR_FIFO_DEPTH.
//  Reset (synchronous, priority over all else):
//   - Queue is emptied, so scr_valid=0.
//   - scr_ovf=0, scr_drops=0, keyboard register=0.
//   - RAM and screen shadow contents are NOT reset.
//   - scr_addr/scr_data are don't-care while scr_valid=0.
//   - A write with writeM=1 during a reset cycle still updates RAM/shadow but does not push.
//   - Reset mid-stream discards queued entries.
// TESTING
//  T1 RAM: write 0x1234 to 0x0010, reading 0x0010 in the same cycle -> inM=old value; next cycle -> inM=0x1234.
//     Read 0x7000 -> inM=0.
//  T2 Keyboard: kbd_valid=1, kbd_code=0x0041 -> next cycle, read 0x6000 -> 0x0041.
//     Write 0xFFFF to 0x6000 -> still 0x0041.
//  T3 Screen path: scr_ready=1, write 0xAAAA to 0x4005 -> next cycle scr_valid=1, scr_addr=5, scr_data=0xAAAA,
//     then empty. Read 0x4005 -> 0xAAAA.
//  T4 Overflow: scr_ready=0, 10 screen writes at DEPTH=8 -> 8 queued, scr_ovf=1, scr_drops=2.
//     Then scr_ready=1 -> 8 entries drain in order, and the shadow holds all 10 values.
//  T5 Full+pop: hold full, scr_ready=1 and push in the same cycle -> accepted, scr_drops unchanged, order preserved.
//  T6 Reset mid-stream: 3 queued, then reset=1 -> next cycle scr_valid=0, scr_ovf=0, scr_drops=0,
//     keyboard=0, and RAM contents are kept.

Source files
------------

// File: rtl/hack_data_memory.sv
// Hack data-memory stage: RAM, screen shadow and keyboard decode, plus a
// valid/ready write queue forwarding screen writes to the display controller.
module hack_data_memory #(
    parameter int unsigned SCR_FIFO_DEPTH = 8,
    parameter int unsigned DROP_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           addressM,
    input  logic [15:0]           outM,
    input  logic                  writeM,
    output logic [15:0]           inM,
    input  logic                  kbd_valid,
    input  logic [15:0]           kbd_code,
    output logic                  scr_valid,
    input  logic                  scr_ready,
    output logic [12:0]           scr_addr,
    output logic [15:0]           scr_data,
    output logic                  scr_ovf,
    output logic [DROP_CNT_W-1:0] scr_drops
);

    localparam int unsigned PTR_W  = $clog2(SCR_FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned RAM_AW = 14;
    localparam int unsigned SCR_AW = 13;

    logic [15:0] ram_q    [2**RAM_AW];
    logic [15:0] shadow_q [2**SCR_AW];

    logic [SCR_AW-1:0] fifo_addr_q [SCR_FIFO_DEPTH];
    logic [15:0]       fifo_data_q [SCR_FIFO_DEPTH];

    logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  ovf_q, ovf_d;
    logic [DROP_CNT_W-1:0] drops_q, drops_d;
    logic [15:0]           kbd_q, kbd_d;

    logic [14:0] a;
    logic        is_ram, is_scr, is_kbd;
    logic        empty, full, pop, push_req, push_ok, push_drop;
    logic        unused_addr_msb;

    // Address decode; bit 15 is not part of the Hack data space.
    assign a               = addressM[14:0];
    assign unused_addr_msb = addressM[15];
    assign is_ram          = (a[14] == 1'b0);
    assign is_scr          = (a[14:13] == 2'b10);
    assign is_kbd          = (a == 15'h6000);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop       = scr_valid && scr_ready;
    assign push_req  = writeM && is_scr && !reset;
    assign push_ok   = push_req && (!full || pop);
    assign push_drop = push_req && full && !pop;

    assign scr_valid = !empty;
    assign scr_addr  = fifo_addr_q[rd_ptr_q[PTR_W-1:0]];
    assign scr_data  = fifo_data_q[rd_ptr_q[PTR_W-1:0]];
    assign scr_ovf   = ovf_q;
    assign scr_drops = drops_q;

    // Zero-latency read path; reads see the pre-edge contents.
    always_comb begin
        inM = 16'h0000;
        if (is_ram) begin
            inM = ram_q[a[RAM_AW-1:0]];
        end else if (is_scr) begin
            inM = shadow_q[a[SCR_AW-1:0]];
        end else if (is_kbd) begin
            inM = kbd_q;
        end
    end

    // Arrays are not reset; writes land even during reset.
    always_ff @(posedge clk) begin
        if (writeM && is_ram) begin
            ram_q[a[RAM_AW-1:0]] <= outM;
        end
        if (writeM && is_scr) begin
            shadow_q[a[SCR_AW-1:0]] <= outM;
        end
        if (push_ok) begin
            fifo_addr_q[wr_ptr_q[PTR_W-1:0]] <= a[SCR_AW-1:0];
            fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= outM;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        drops_d  = drops_q;
        kbd_d    = kbd_q;
        if (kbd_valid) begin
            kbd_d = kbd_code;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + CNT_W'(1);
        end
        if (push_drop) begin
            ovf_d = 1'b1;
            if (drops_q != {DROP_CNT_W{1'b1}}) begin
                drops_d = drops_q + DROP_CNT_W'(1);
            end
        end
        if (reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            drops_d  = '0;
            kbd_d    = 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        ovf_q    <= ovf_d;
        drops_q  <= drops_d;
        kbd_q    <= kbd_d;
    end

endmodule

// File: tb/tb_hack_data_memory.sv
// Directed bench for hack_data_memory: memory map, keyboard, screen queue,
// overflow, full-with-pop and mid-stream reset.
module tb_hack_data_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addressM, outM, inM, kbd_code, scr_data;
    logic        writeM, kbd_valid, scr_valid, scr_ready, scr_ovf;
    logic [12:0] scr_addr;
    logic [7:0]  scr_drops;

    int n_checks = 0;
    int n_fail   = 0;

    hack_data_memory #(.SCR_FIFO_DEPTH(8), .DROP_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .addressM(addressM), .outM(outM),
        .writeM(writeM), .inM(inM), .kbd_valid(kbd_valid), .kbd_code(kbd_code),
        .scr_valid(scr_valid), .scr_ready(scr_ready), .scr_addr(scr_addr),
        .scr_data(scr_data), .scr_ovf(scr_ovf), .scr_drops(scr_drops)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] addr);
        addressM = addr;
        writeM   = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        addressM = addr;
        outM     = data;
        writeM   = 1'b1;
        tick();
        writeM   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addressM = 16'h0; outM = 16'h0; writeM = 1'b0;
        kbd_valid = 1'b0; kbd_code = 16'h0; scr_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        rd(16'h6000);
        check("rst_valid", 16'(scr_valid), 16'h0);
        check("rst_ovf",   16'(scr_ovf),   16'h0);
        check("rst_drops", 16'(scr_drops), 16'h0);
        check("rst_kbd",   inM,            16'h0);

        // T1: RAM read-during-write returns old value
        wr(16'h0010, 16'h5555);
        addressM = 16'h0010; outM = 16'h1234; writeM = 1'b1; #1;
        check("ram_rdw_old", inM, 16'h5555);
        tick(); writeM = 1'b0; #1;
        check("ram_new", inM, 16'h1234);
        rd(16'h8010);
        check("ram_msb_ignored", inM, 16'h1234);
        wr(16'h7000, 16'hBEEF);
        rd(16'h7000);
        check("unmapped_zero", inM, 16'h0);

        // T2: keyboard load, read-during-load old, write ignored
        addressM = 16'h6000; kbd_valid = 1'b1; kbd_code = 16'h0041; #1;
        check("kbd_old", inM, 16'h0);
        tick(); kbd_valid = 1'b0; kbd_code = 16'h9999; #1;
        check("kbd_new", inM, 16'h0041);
        wr(16'h6000, 16'hFFFF);
        rd(16'h6000);
        check("kbd_wr_ignored", inM, 16'h0041);
        check("kbd_no_push", 16'(scr_valid), 16'h0);

        // T3: single screen write, no bypass
        scr_ready = 1'b1;
        addressM = 16'h4005; outM = 16'hAAAA; writeM = 1'b1; #1;
        check("scr_no_bypass", 16'(scr_valid), 16'h0);
        tick(); writeM = 1'b0; #1;
        check("scr_valid", 16'(scr_valid), 16'h1);
        check("scr_addr",  16'(scr_addr),  16'h0005);
        check("scr_data",  scr_data,       16'hAAAA);
        tick();
        check("scr_empty", 16'(scr_valid), 16'h0);
        rd(16'h4005);
        check("scr_shadow", inM, 16'hAAAA);

        // T4: overflow with 10 writes into 8 entries
        scr_ready = 1'b0;
        for (int i = 0; i < 10; i++) wr(16'h4100 + 16'(i), 16'hB000 + 16'(i));
        #1;
        check("ovf_valid", 16'(scr_valid), 16'h1);
        check("ovf_flag",  16'(scr_ovf),   16'h1);
        check("ovf_drops", 16'(scr_drops), 16'h2);
        tick();
        check("ovf_hold_addr", 16'(scr_addr), 16'h0100);
        check("ovf_hold_data", scr_data,      16'hB000);
        scr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("drain_valid", 16'(scr_valid), 16'h1);
            check("drain_addr",  16'(scr_addr),  16'h0100 + 16'(i));
            check("drain_data",  scr_data,       16'hB000 + 16'(i));
            tick();
        end
        check("drain_empty", 16'(scr_valid), 16'h0);
        for (int i = 0; i < 10; i++) begin
            rd(16'h4100 + 16'(i));
            check("ovf_shadow", inM, 16'hB000 + 16'(i));
        end

        // T5: full with simultaneous pop accepts the push
        scr_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(16'h4200 + 16'(i), 16'hC000 + 16'(i));
        scr_ready = 1'b1;
        wr(16'h4208, 16'hC008);
        check("fullpop_drops", 16'(scr_drops), 16'h2);
        for (int i = 1; i < 9; i++) begin
            #1;
            check("fullpop_valid", 16'(scr_valid), 16'h1);
            check("fullpop_addr",  16'(scr_addr),  16'h0200 + 16'(i));
            check("fullpop_data",  scr_data,       16'hC000 + 16'(i));
            tick();
        end
        check("fullpop_empty", 16'(scr_valid), 16'h0);

        // T6: reset mid-stream; a write during reset updates the shadow only
        scr_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr(16'h4300 + 16'(i), 16'hD000 + 16'(i));
        check("pre_rst_valid", 16'(scr_valid), 16'h1);
        reset = 1'b1;
        wr(16'h4400, 16'hEEEE);
        reset = 1'b0;
        rd(16'h6000);
        check("mid_rst_valid", 16'(scr_valid), 16'h0);
        check("mid_rst_ovf",   16'(scr_ovf),   16'h0);
        check("mid_rst_drops", 16'(scr_drops), 16'h0);
        check("mid_rst_kbd",   inM,            16'h0);
        rd(16'h0010);
        check("mid_rst_ram", inM, 16'h1234);
        rd(16'h4400);
        check("rst_write_shadow", inM, 16'hEEEE);
        tick();
        check("rst_write_no_push", 16'(scr_valid), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
